// File: rtl/systolic_array_nxn.sv
// Output-stationary NxN systolic MAC array computing C = A x B, with internal operand skew,
// start/valid/ready control, K-tiling accumulation and runtime ReLU. Optional macro SYSTOLIC_SAT_EN.
module systolic_array_nxn #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       acc_keep,
  input  logic                       activation,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*WIDTH-1:0]         a_col_in,
  input  logic [N*WIDTH-1:0]         b_row_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*N*ACC_WIDTH-1:0]   c_out,
  output logic                       busy
);

  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]            drain_cnt_q, drain_cnt_d;
  logic                     relu_q, relu_d;
  logic [N*N*ACC_WIDTH-1:0] c_out_q, c_out_d;
  logic                     accept, clear_acc, capture;

  logic [WIDTH-1:0]         a_west  [N];
  logic [WIDTH-1:0]         b_north [N];
  logic [WIDTH-1:0]         a_east  [N][N-1];
  logic [WIDTH-1:0]         b_south [N-1][N];
  logic [ACC_WIDTH-1:0]     acc_w   [N][N];

  assign accept    = (state_q == S_LOAD) && in_valid;
  assign clear_acc = (state_q == S_IDLE) && start && !acc_keep;
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign c_out     = c_out_q;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    relu_d      = relu_q;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_LOAD;
        beat_cnt_d = '0;
        relu_d     = activation;
      end
      S_LOAD: if (in_valid) begin
        if (beat_cnt_q == CW'(N - 1)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
      // Last PE update lands 2N-1 edges after the final accept; capture one edge later.
      S_DRAIN: if (drain_cnt_q == CW'(2 * N - 1)) begin
        state_d = S_DONE;
        capture = 1'b1;
      end else begin
        drain_cnt_d = drain_cnt_q + CW'(1);
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    c_out_d = c_out_q;
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          c_out_d[(i*N+j)*ACC_WIDTH +: ACC_WIDTH] =
            (relu_q && acc_w[i][j][ACC_WIDTH-1]) ? '0 : acc_w[i][j];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      relu_q      <= 1'b0;
      c_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      relu_q      <= relu_d;
      c_out_q     <= c_out_d;
    end
  end

  // Input register plus skew: row r of A and column r of B see r+1 stages; idle cycles inject zeros.
  for (genvar r = 0; r < N; r++) begin : g_skew
    logic [WIDTH-1:0] a_sh_q [r+1];
    logic [WIDTH-1:0] a_sh_d [r+1];
    logic [WIDTH-1:0] b_sh_q [r+1];
    logic [WIDTH-1:0] b_sh_d [r+1];

    always_comb begin
      a_sh_d[0] = accept ? a_col_in[r*WIDTH +: WIDTH] : '0;
      b_sh_d[0] = accept ? b_row_in[r*WIDTH +: WIDTH] : '0;
      for (int k = 1; k <= r; k++) begin
        a_sh_d[k] = a_sh_q[k-1];
        b_sh_d[k] = b_sh_q[k-1];
      end
    end

    // NOTE: the skew register arrays are reset too, so an aborted tile leaves no stale operand behind.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k <= r; k++) begin
          a_sh_q[k] <= '0;
          b_sh_q[k] <= '0;
        end
      end else begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
      end
    end

    assign a_west[r]  = a_sh_q[r];
    assign b_north[r] = b_sh_q[r];
  end

  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe_col
      logic [WIDTH-1:0]            a_in, b_in;
      logic signed [2*WIDTH-1:0]   a_ext, b_ext, prod;
      logic [ACC_WIDTH-1:0]        acc_q, acc_d;

      if (j == 0) begin : g_a_edge
        assign a_in = a_west[i];
      end else begin : g_a_inner
        assign a_in = a_east[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_north[j];
      end else begin : g_b_inner
        assign b_in = b_south[i-1][j];
      end

      assign a_ext = {{WIDTH{a_in[WIDTH-1]}}, a_in};
      assign b_ext = {{WIDTH{b_in[WIDTH-1]}}, b_in};
      assign prod  = a_ext * b_ext;

`ifdef SYSTOLIC_SAT_EN
      localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      logic signed [ACC_WIDTH:0] prod_x, sum;
      logic                      sat_q, sat_d;

      assign prod_x = (ACC_WIDTH+1)'(prod);
      assign sum    = {acc_q[ACC_WIDTH-1], acc_q} + prod_x;

      // Once clamped, the accumulator holds until the next clear.
      always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clear_acc) begin
          acc_d = '0;
          sat_d = 1'b0;
        end else if (!sat_q) begin
          if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            sat_d = 1'b1;
          end else begin
            acc_d = sum[ACC_WIDTH-1:0];
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sat_q <= 1'b0;
        else      sat_q <= sat_d;
      end
`else
      logic [ACC_WIDTH-1:0] prod_x;

      assign prod_x = ACC_WIDTH'(prod);

      always_comb begin
        acc_d = clear_acc ? '0 : acc_q + prod_x;
      end
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
      end
      assign acc_w[i][j] = acc_q;

      if (j < N - 1) begin : g_pass_a
        logic [WIDTH-1:0] a_pass_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) a_pass_q <= '0;
          else      a_pass_q <= a_in;
        end
        assign a_east[i][j] = a_pass_q;
      end
      if (i < N - 1) begin : g_pass_b
        logic [WIDTH-1:0] b_pass_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) b_pass_q <= '0;
          else      b_pass_q <= b_in;
        end
        assign b_south[i][j] = b_pass_q;
      end
    end
  end

endmodule
